// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture / SRAM controller.
//   ADDR_W_DEF : default SRAM address width (32768 words)
//   DATA_W_DEF : default sample / SRAM word width
//   cap_state_e: capture FSM state encoding
package adc_capture_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_e;

endpackage

// File: rtl/adc_capture_rd_pipe.sv
// Read return pipeline for the capture SRAM.
// A read accepted in cycle T has its SRAM access in T+1, SRAM Q valid in T+2,
// and is returned registered in T+3 as a single-cycle rd_vld pulse.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   rd_acc     : read accepted this cycle (cycle T)
//   sram_q     : SRAM read data (valid one cycle after the access)
//   rd_vld     : read return strobe (T+3)
//   rd_data    : registered SRAM data
module adc_capture_rd_pipe
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              rd_acc,
  input  logic [DATA_W-1:0] sram_q,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_data
);

  logic vld_p1;
  logic vld_p2;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      // p1: SRAM access cycle
      vld_p1 <= rd_acc;
      // p2: SRAM Q valid
      vld_p2 <= vld_p1;
      // output: Q captured and presented
      rd_vld <= vld_p2;
      if (vld_p2) rd_data <= sram_q;
    end
  end

endmodule

// File: rtl/adc_capture_sram_ctrl.sv
// ADC capture controller driving a single-port 32768x9 SRAM wrapper.
// Captures adc_data samples into SRAM (address 0 upward) after cfg_start,
// until cfg_len+1 samples are stored or cfg_stop arrives, then allows
// pipelined readout through rd_req/rd_ack (one read per cycle, data at T+3).
// Ports:
//   CLK, RST_N               : clock, asynchronous active-low reset
//   cfg_start/cfg_stop       : start / early-stop pulses; cfg_len = length-1
//   adc_vld/adc_data         : sample strobe and value
//   busy/done                : capturing / capture finished (until next start)
//   wr_cnt                   : samples stored in current/last capture
//   rd_req/rd_addr/rd_ack    : readout request handshake (rd_ack combinational)
//   rd_vld/rd_data           : readout return
//   sram_ceb/web/a/d, sram_q : SRAM pins (active-low enables, registered)
// Build option ADC_CAPTURE_RING_EN: ring capture; address wraps to 0 after
// len, capture runs until cfg_stop, sticky 'wrapped' output, wr_cnt
// saturates at len+1.
module adc_capture_sram_ctrl
  import adc_capture_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic              adc_vld,
  input  logic [DATA_W-1:0] adc_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_cnt,
`ifdef ADC_CAPTURE_RING_EN
  output logic              wrapped,
`endif
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_data,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  cap_state_e        state_q;
  cap_state_e        state_d;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] wr_addr;
  logic              start_acc;
  logic              wr_en;
  logic              last_wr;

  assign start_acc = cfg_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // Reads are only accepted outside capture, so a read and a write can never
  // land on the SRAM pins in the same cycle; a starting capture takes priority.
  assign rd_ack    = rd_req && (state_q != ST_CAPTURE) && !cfg_start;
  assign busy      = (state_q == ST_CAPTURE);
  assign done      = (state_q == ST_DONE);

`ifdef ADC_CAPTURE_RING_EN
  logic [ADDR_W-1:0] wr_ptr;
  assign wr_addr = wr_ptr;
`else
  assign wr_addr = wr_cnt[ADDR_W-1:0];
`endif
  assign last_wr = (wr_addr == len_q);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cfg_start) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        wr_en = adc_vld;
        // A sample arriving with cfg_stop is still written.
        if (cfg_stop) state_d = ST_DONE;
`ifndef ADC_CAPTURE_RING_EN
        else if (adc_vld && last_wr) state_d = ST_DONE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      len_q   <= '0;
      wr_cnt  <= '0;
`ifdef ADC_CAPTURE_RING_EN
      wr_ptr  <= '0;
      wrapped <= 1'b0;
`endif
    end else if (start_acc) begin
      len_q   <= cfg_len;
      wr_cnt  <= '0;
`ifdef ADC_CAPTURE_RING_EN
      wr_ptr  <= '0;
      wrapped <= 1'b0;
`endif
    end else if (wr_en) begin
`ifdef ADC_CAPTURE_RING_EN
      if (last_wr) begin
        wr_ptr  <= '0;
        wrapped <= 1'b1;
      end else begin
        wr_ptr  <= wr_ptr + ADDR_W'(1);
      end
      // Count stops at the ring size once the buffer is full.
      if (wr_cnt != ({1'b0, len_q} + (ADDR_W+1)'(1)))
        wr_cnt <= wr_cnt + (ADDR_W+1)'(1);
`else
      wr_cnt <= wr_cnt + (ADDR_W+1)'(1);
`endif
    end
  end

  // SRAM pins are registered: the access happens the cycle after the
  // sample / read acceptance. Enables return high on every idle cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sram_ceb <= 1'b1;
      sram_web <= 1'b1;
      sram_a   <= '0;
      sram_d   <= '0;
    end else begin
      sram_ceb <= 1'b1;
      sram_web <= 1'b1;
      if (wr_en) begin
        sram_ceb <= 1'b0;
        sram_web <= 1'b0;
        sram_a   <= wr_addr;
        sram_d   <= adc_data;
      end else if (rd_ack) begin
        sram_ceb <= 1'b0;
        sram_a   <= rd_addr;
      end
    end
  end

  adc_capture_rd_pipe #(
    .DATA_W (DATA_W)
  ) u_rd_pipe (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .rd_acc  (rd_ack),
    .sram_q  (sram_q),
    .rd_vld  (rd_vld),
    .rd_data (rd_data)
  );

endmodule

// File: doc/adc_capture_sram_ctrl.md
ADC_CAPTURE_SRAM_CTRL -- requirements
Module: adc_capture_sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, SRAM address width (32768 words).
REQ-002 SHALL have parameter DATA_W, default 9, sample/SRAM word width.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cfg_start  input  1  one-cycle pulse, begin capture.
REQ-006 SHALL have port cfg_stop  input  1  one-cycle pulse, end capture early.
REQ-007 SHALL have port cfg_len  input  ADDR_W  capture length minus one, sampled on accepted cfg_start.
REQ-008 SHALL have port adc_vld  input  1  sample strobe.
REQ-009 SHALL have port adc_data  input  DATA_W  sample value.
REQ-010 SHALL have ports busy/done  output  1 each  CAPTURE state / capture finished (sticky until next start).
REQ-011 SHALL have port wr_cnt  output  ADDR_W+1  samples stored in current/last capture.
REQ-012 SHALL have ports rd_req input 1, rd_addr input ADDR_W, rd_ack output 1  readout request handshake.
REQ-013 SHALL have ports rd_vld output 1, rd_data output DATA_W  readout return.
REQ-014 SHALL have ports sram_ceb, sram_web output 1, sram_a output ADDR_W, sram_d output DATA_W, sram_q input DATA_W  to spsram32768x9_wrapper (CEB/WEB active low, Q valid one cycle after read).

Function
REQ-015 SHALL implement FSM states IDLE, CAPTURE, DONE.
REQ-016 SHALL, on cfg_start in IDLE or DONE, latch cfg_len, clear wr_cnt and done, enter CAPTURE; cfg_start in CAPTURE ignored.
REQ-017 SHALL, in CAPTURE with adc_vld=1, write adc_data to address wr_cnt[ADDR_W-1:0]; SRAM pins registered, write appears one cycle after the sample cycle.
REQ-018 SHALL, on the write where wr_cnt equals latched len, increment wr_cnt, enter DONE, set done.
REQ-019 SHALL, on cfg_stop in CAPTURE, write any sample valid that same cycle, then enter DONE with done=1; cfg_stop outside CAPTURE ignored.
REQ-020 SHALL ignore adc_vld in IDLE and DONE (no SRAM access).
REQ-021 SHALL assert rd_ack combinationally with rd_req only when state is not CAPTURE and cfg_start is low; cfg_start wins over simultaneous rd_req.
REQ-022 SHALL, for a read accepted at cycle T, drive CEB=0/WEB=1/A=rd_addr at T+1 and assert rd_vld for exactly one cycle at T+3 with rd_data = registered sram_q.
REQ-023 SHALL sustain one accepted read per cycle; reads in flight at cfg_start complete normally.
REQ-024 SHALL hold sram_ceb=1, sram_web=1 on all idle cycles; never issue read and write in one cycle.
REQ-025 SHALL saturate nothing: len=32767 stores 32768 samples, wr_cnt=32768.

Reset
REQ-026 SHALL, on RST_N low, asynchronously set state=IDLE, busy=0, done=0, wr_cnt=0, rd_ack path idle, rd_vld=0, rd_data=0, sram_ceb=1, sram_web=1, sram_a=0, sram_d=0.
REQ-027 SHALL, on reset mid-capture or mid-read, abandon the operation; no rd_vld after reset release for pre-reset requests.

Configuration
REQ-028 SHALL support macro ADC_CAPTURE_RING_EN: defined, address wraps to 0 after len instead of entering DONE, capture continues until cfg_stop, output wrapped (1 bit, sticky, reset 0) set on first wrap, wr_cnt saturates at len+1; undefined, REQ-018 applies and no wrapped port exists.

Structure
REQ-029 SHALL place ADDR_W/DATA_W defaults and FSM state encoding in shared package adc_capture_pkg.
REQ-030 SHALL keep the read return pipeline (T+1..T+3 valid tracking) in sub-module adc_capture_rd_pipe; SRAM instantiated outside this block.

Verification
REQ-031 SHALL cover: start len=3, adc_vld 4 cycles data 0x001..0x004 -> writes A=0..3, done=1, wr_cnt=4, busy=0.
REQ-032 SHALL cover: after REQ-031, rd_req addr 0..3 back-to-back -> rd_vld 4 consecutive cycles from T+3, data 0x001..0x004.
REQ-033 SHALL cover: rd_req during CAPTURE -> rd_ack=0, no SRAM read; rd_req with cfg_start same cycle -> rd_ack=0, capture starts.
REQ-034 SHALL cover: start len=100, cfg_stop with adc_vld at 10th sample -> 10 writes, wr_cnt=10, done=1.
REQ-035 SHALL cover: RST_N low mid-capture and with reads in flight -> all outputs to REQ-026 values, no spurious rd_vld.
REQ-036 SHALL cover (ADC_CAPTURE_RING_EN): len=3, 6 samples then stop -> addresses 0,1,2,3,0,1, wrapped=1, wr_cnt=4.
